// File: rtl/uart_rx_frontend_pkg.sv
// uart_pkg: shared state encoding, data width and majority-vote helper for the UART receive front end
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: valid/ready byte stream from the receive front end to the rx FIFO
interface uart_rx_frontend_if;
    import uart_pkg::*;

    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/uart_rx_frontend_bit_sampler.sv
// bit_sampler: rxd synchroniser, bit timer and 3-sample majority vote around each bit centre
module bit_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALER   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rxd,
    input  logic arm,
    input  logic hold,
    output logic rxd_sync,
    output logic sample_valid,
    output logic sample_bit
);

    localparam int CNT_W = $clog2(PRESCALER);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(PRESCALER / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PRESCALER - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign rxd_sync     = sync_q[SYNC_STAGES-1];
    // Timer reaches zero one cycle after the bit centre, when all three votes are in
    assign sample_valid = (cnt_q == '0);
    assign sample_bit   = vote3(hist_q[1], hist_q[0], rxd_sync);

    // Next synchroniser/history state; the timer reloads from its own zero so bit centres never drift
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
        hist_d = {hist_q[0], rxd_sync};
        cnt_d  = arm ? HALF : (hold || cnt_q == '0) ? FULL : cnt_q - CNT_W'(1);
    end

    // Line idles high, so the synchroniser and vote history reset to ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= '1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 receiver with framing/overrun detection and saturating error counters (UART_RX_PARITY_EN adds even parity)
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int PRESCALER   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    uart_rx_frontend_if.master   m,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0] overrun_cnt
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] parity_cnt
`endif
);

    rx_state_e            state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0] frame_cnt_q, frame_cnt_d, overrun_cnt_q, overrun_cnt_d;
    logic                 arm, hold, drop;
    logic                 rxd_sync, sample_valid, sample_bit;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, parity_err_q, parity_err_d;
    logic [ERR_CNT_W-1:0] parity_cnt_q, parity_cnt_d;
    assign drop       = par_bad_q;
    assign parity_err = parity_err_q;
    assign parity_cnt = parity_cnt_q;
`else
    assign drop = 1'b0;
`endif

    bit_sampler #(.PRESCALER(PRESCALER), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
        .clk          (clk),
        .reset_n      (reset_n),
        .rxd          (rxd),
        .arm          (arm),
        .hold         (hold),
        .rxd_sync     (rxd_sync),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit)
    );

    assign m.m_valid   = valid_q;
    assign m.m_data    = data_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

    // Frame FSM, output handshake and error counting; a new byte load overrides a same-cycle accept
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !m.m_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        arm         = 1'b0;
        hold        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxd_sync) begin
                    arm     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (sample_valid) begin
                    state_d = sample_bit ? IDLE : DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (sample_valid) begin
                    shift_d[idx_q] = sample_bit;
                    idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_valid) begin
                    par_bad_d    = sample_bit ^ (^shift_q);
                    parity_err_d = par_bad_d;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_valid) begin
                    if (!sample_bit) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else begin
                        // Leave half a bit early so the next start edge is caught promptly
                        state_d = IDLE;
                        if (!drop) begin
                            if (!valid_q || m.m_ready) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
            end
            BREAK: begin
                // Any low sample restarts the one-bit idle qualification
                if (!rxd_sync) hold = 1'b1;
                else if (sample_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        frame_cnt_d   = frame_cnt_q + ERR_CNT_W'(frame_err_d && !(&frame_cnt_q));
        overrun_cnt_d = overrun_cnt_q + ERR_CNT_W'(overrun_d && !(&overrun_cnt_q));
`ifdef UART_RX_PARITY_EN
        parity_cnt_d  = parity_cnt_q + ERR_CNT_W'(parity_err_d && !(&parity_cnt_q));
`endif
    end

    // State and output registers; reset drops any partial frame silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
            parity_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
            parity_cnt_q  <= parity_cnt_d;
`endif
        end
    end

endmodule
